qspi_sram_responder: RTL and testbench



---
 rtl/qspi_sram_responder.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_qspi_sram_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_sram_responder.sv
// 23LC512-compatible SPI/SQI serial-SRAM responder: oversamples the QSPI pins on clk, decodes
// READ/WRITE/RDMR/WRMR/EQIO/RSTIO and serves a 64KB synchronous byte RAM.
module qspi_sram_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  MR_RESET    = 8'h40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        qspi_cs_n_i,
  input  logic        qspi_sck_i,
  input  logic [3:0]  qspi_sio_i,
  output logic [3:0]  qspi_sio_o,
  output logic [3:0]  qspi_sio_oe,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        sqi_mode
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CMD    = 4'd1,
    ST_ADDR   = 4'd2,
    ST_DUMMY  = 4'd3,
    ST_RDATA  = 4'd4,
    ST_WDATA  = 4'd5,
    ST_RDMR   = 4'd6,
    ST_WRMR   = 4'd7,
    ST_IGNORE = 4'd8
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDMR  = 8'h05;
  localparam logic [7:0] CMD_WRMR  = 8'h01;
  localparam logic [7:0] CMD_EQIO  = 8'h38;
  localparam logic [7:0] CMD_RSTIO = 8'hFF;

  logic [SYNC_STAGES-1:0]      cs_sync_q;
  logic [SYNC_STAGES-1:0]      sck_sync_q;
  logic [SYNC_STAGES-1:0][3:0] sio_sync_q;
  logic                        sck_prev_q;

  logic       cs_s, sck_s, sck_rise_s, sck_fall_s;
  logic [3:0] sio_s;
  logic       last_bit_s, last_out_s;
  logic [7:0] byte_in_s;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic [7:0]  shift_in_q, shift_in_d;
  logic [7:0]  shift_out_q, shift_out_d;
  logic [7:0]  prefetch_q, prefetch_d;
  logic [7:0]  addr_hi_q, addr_hi_d;
  logic        addr_byte_q, addr_byte_d;
  logic        cmd_read_q, cmd_read_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        rvalid_q, rvalid_d;
  logic        rfirst_q, rfirst_d;
  logic        sqi_q, sqi_d;
  logic [7:0]  mr_q, mr_d;
  logic [3:0]  sio_o_q, sio_o_d;
  logic [3:0]  sio_oe_q, sio_oe_d;

  // Input synchronizers; SCK gets one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      sio_sync_q <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], qspi_cs_n_i};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], qspi_sck_i};
      sio_sync_q <= {sio_sync_q[SYNC_STAGES-2:0], qspi_sio_i};
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign sio_s      = sio_sync_q[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_prev_q;
  assign sck_fall_s = ~sck_s & sck_prev_q;
  assign last_bit_s = sqi_q ? (bit_cnt_q == 3'd1) : (bit_cnt_q == 3'd7);
  assign last_out_s = sqi_q ? (out_cnt_q == 3'd1) : (out_cnt_q == 3'd7);
  assign byte_in_s  = sqi_q ? {shift_in_q[3:0], sio_s} : {shift_in_q[6:0], sio_s[0]};

  // Next-state, datapath and memory-strobe logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    out_cnt_d   = out_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    prefetch_d  = prefetch_q;
    addr_hi_d   = addr_hi_q;
    addr_byte_d = addr_byte_q;
    cmd_read_d  = cmd_read_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rvalid_d    = mem_re_q;
    rfirst_d    = rfirst_q;
    sqi_d       = sqi_q;
    mr_d        = mr_q;
    sio_o_d     = sio_o_q;
    // A write strobe always advances the address on the following clk.
    if (mem_we_q) begin
      mem_addr_d = mem_addr_q + 16'd1;
    end else begin
      mem_addr_d = mem_addr_q;
    end

    if (cs_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      out_cnt_d = 3'd0;
      rfirst_d  = 1'b0;
      sio_o_d   = 4'b0000;
    end else begin
      // Read return: first byte goes straight to the shifter and triggers the prefetch.
      if (rvalid_q && (state_q == ST_RDATA)) begin
        if (rfirst_q) begin
          shift_out_d = mem_rdata;
          mem_addr_d  = mem_addr_q + 16'd1;
          mem_re_d    = 1'b1;
          rfirst_d    = 1'b0;
        end else begin
          prefetch_d = mem_rdata;
        end
      end else begin
        prefetch_d = prefetch_q;
      end

      case (state_q)
        ST_IDLE: begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
          out_cnt_d = 3'd0;
        end
        ST_CMD, ST_ADDR, ST_DUMMY, ST_WDATA, ST_WRMR: begin
          if (sck_rise_s) begin
            shift_in_d = byte_in_s;
            if (last_bit_s) begin
              bit_cnt_d = 3'd0;
              case (state_q)
                ST_CMD: begin
                  case (byte_in_s)
                    CMD_READ: begin
                      cmd_read_d  = 1'b1;
                      addr_byte_d = 1'b0;
                      state_d     = ST_ADDR;
                    end
                    CMD_WRITE: begin
                      cmd_read_d  = 1'b0;
                      addr_byte_d = 1'b0;
                      state_d     = ST_ADDR;
                    end
                    CMD_RDMR: begin
                      shift_out_d = mr_q;
                      out_cnt_d   = 3'd0;
                      state_d     = ST_RDMR;
                    end
                    CMD_WRMR: state_d = ST_WRMR;
                    CMD_EQIO: begin
                      sqi_d   = 1'b1;
                      state_d = ST_IGNORE;
                    end
                    CMD_RSTIO: begin
                      sqi_d   = 1'b0;
                      state_d = ST_IGNORE;
                    end
                    default: state_d = ST_IGNORE;
                  endcase
                end
                ST_ADDR: begin
                  if (!addr_byte_q) begin
                    addr_hi_d   = byte_in_s;
                    addr_byte_d = 1'b1;
                  end else begin
                    mem_addr_d = {addr_hi_q, byte_in_s};
                    if (!cmd_read_q) begin
                      state_d = ST_WDATA;
                    end else if (sqi_q) begin
                      state_d = ST_DUMMY;
                    end else begin
                      mem_re_d  = 1'b1;
                      rfirst_d  = 1'b1;
                      out_cnt_d = 3'd0;
                      state_d   = ST_RDATA;
                    end
                  end
                end
                ST_DUMMY: begin
                  mem_re_d  = 1'b1;
                  rfirst_d  = 1'b1;
                  out_cnt_d = 3'd0;
                  state_d   = ST_RDATA;
                end
                ST_WDATA: begin
                  mem_wdata_d = byte_in_s;
                  mem_we_d    = 1'b1;
                end
                ST_WRMR: begin
                  mr_d    = {byte_in_s[7:6], MR_RESET[5:0]};
                  state_d = ST_IGNORE;
                end
                default: state_d = ST_IGNORE;
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_RDATA, ST_RDMR: begin
          if (sck_fall_s) begin
            sio_o_d = sqi_q ? shift_out_q[7:4] : {2'b00, shift_out_q[7], 1'b0};
            if (last_out_s) begin
              out_cnt_d = 3'd0;
              if (state_q == ST_RDATA) begin
                shift_out_d = prefetch_q;
                mem_addr_d  = mem_addr_q + 16'd1;
                mem_re_d    = 1'b1;
              end else begin
                shift_out_d = mr_q;
              end
            end else begin
              out_cnt_d   = out_cnt_q + 3'd1;
              shift_out_d = sqi_q ? {shift_out_q[3:0], 4'b0000} : {shift_out_q[6:0], 1'b0};
            end
          end else begin
            out_cnt_d = out_cnt_q;
          end
        end
        default: state_d = state_q;
      endcase
    end

    if ((state_d == ST_RDATA) || (state_d == ST_RDMR)) begin
      sio_oe_d = sqi_d ? 4'b1111 : 4'b0010;
    end else begin
      sio_oe_d = 4'b0000;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      out_cnt_q   <= 3'd0;
      shift_in_q  <= 8'h00;
      shift_out_q <= 8'h00;
      prefetch_q  <= 8'h00;
      addr_hi_q   <= 8'h00;
      addr_byte_q <= 1'b0;
      cmd_read_q  <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      rvalid_q    <= 1'b0;
      rfirst_q    <= 1'b0;
      sqi_q       <= 1'b0;
      mr_q        <= MR_RESET;
      sio_o_q     <= 4'b0000;
      sio_oe_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      out_cnt_q   <= out_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      prefetch_q  <= prefetch_d;
      addr_hi_q   <= addr_hi_d;
      addr_byte_q <= addr_byte_d;
      cmd_read_q  <= cmd_read_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rvalid_q    <= rvalid_d;
      rfirst_q    <= rfirst_d;
      sqi_q       <= sqi_d;
      mr_q        <= mr_d;
      sio_o_q     <= sio_o_d;
      sio_oe_q    <= sio_oe_d;
    end
  end

  assign qspi_sio_o  = sio_o_q;
  assign qspi_sio_oe = sio_oe_q;
  assign mem_addr    = mem_addr_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign sqi_mode    = sqi_q;

endmodule

// File: tb/tb_qspi_sram_responder.sv
// Scoreboard bench for qspi_sram_responder: bus-level initiator, RAM model, reference memory.
module tb_qspi_sram_responder;
  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        sck = 1'b0;
  logic [3:0]  sio_i = 4'h0;
  logic [3:0]  sio_o, sio_oe;
  logic [15:0] mem_addr;
  logic        mem_re, mem_we, sqi_mode;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  mem_wdata;

  int checks = 0;
  int errors = 0;
  logic [7:0]  seed8;
  logic [7:0]  ram [0:65535];
  bit          ram_w [0:65535];
  logic [7:0]  ref_mem [int];
  logic [23:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  obs_rd [$];
  bit          m_sqi;
  logic [7:0]  m_mr;

  qspi_sram_responder #(.SYNC_STAGES(2), .MR_RESET(8'h40)) dut (
    .clk(clk), .rst_n(rst_n), .qspi_cs_n_i(cs_n), .qspi_sck_i(sck), .qspi_sio_i(sio_i),
    .qspi_sio_o(sio_o), .qspi_sio_oe(sio_oe), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata), .sqi_mode(sqi_mode));

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ {a[14:8], a[15]} ^ seed8;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  // RAM: read data valid the clk after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram_w[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    if (mem_we) begin
      ram[mem_addr]   <= mem_wdata;
      ram_w[mem_addr] <= 1'b1;
    end
  end

  // Monitor: memory writes and received read bytes against the scoreboard.
  always @(negedge clk) begin
    logic [23:0] e;
    logic [7:0]  eb, ob;
    if (rst_n) begin
      if (mem_we) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%h data=%h, expected none", mem_addr, mem_wdata);
        end else begin
          e = exp_wr.pop_front();
          if ({mem_addr, mem_wdata} !== e) begin
            errors++;
            $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                     mem_addr, mem_wdata, e[23:8], e[7:0]);
          end
        end
      end
      if (mem_re || mem_we) begin
        checks++;
        if (mem_re && mem_we) begin
          errors++;
          $display("FAIL strobe_excl got re=1 we=1 expected at most one");
        end
      end
      if (obs_rd.size() > 0) begin
        ob = obs_rd.pop_front();
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL read_data got %h expected none", ob);
        end else begin
          eb = exp_rd.pop_front();
          if (ob !== eb) begin
            errors++;
            $display("FAIL read_data got %h expected %h", ob, eb);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic begin_txn();
    @(negedge clk);
    cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic end_txn();
    #(HALF);
    cs_n  = 1'b1;
    sio_i = 4'h0;
    #(HALF * 3);
    chk("idle_oe", {28'd0, sio_oe}, 32'd0);
    chk("sqi_mode", {31'd0, sqi_mode}, {31'd0, m_sqi});
  endtask

  // One byte on the bus at the current modelled width; checks OE at every rising edge.
  task automatic xfer(input logic [7:0] tx, input logic [3:0] exp_oe, output logic [7:0] rx);
    rx = 8'h00;
    if (m_sqi) begin
      for (int n = 0; n < 2; n++) begin
        sio_i = (n == 0) ? tx[7:4] : tx[3:0];
        #(HALF); sck = 1'b1;
        rx = {rx[3:0], sio_o};
        chk("oe", {28'd0, sio_oe}, {28'd0, exp_oe});
        #(HALF); sck = 1'b0;
      end
    end else begin
      for (int n = 7; n >= 0; n--) begin
        sio_i = {3'b000, tx[n]};
        #(HALF); sck = 1'b1;
        rx = {rx[6:0], sio_o[1]};
        chk("oe", {28'd0, sio_oe}, {28'd0, exp_oe});
        #(HALF); sck = 1'b0;
      end
    end
  endtask

  task automatic do_write(input logic [15:0] a, input int n, input bit partial);
    logic [7:0] rx, d;
    logic [15:0] ai;
    begin_txn();
    xfer(8'h02, 4'h0, rx);
    xfer(a[15:8], 4'h0, rx);
    xfer(a[7:0], 4'h0, rx);
    for (int i = 0; i < n; i++) begin
      d  = 8'($urandom);
      ai = a + i[15:0];
      ref_mem[int'(ai)] = d;
      exp_wr.push_back({ai, d});
      xfer(d, 4'h0, rx);
    end
    if (partial) begin
      for (int b = 0; b < 4; b++) begin
        sio_i = {3'b000, 1'($urandom)};
        #(HALF); sck = 1'b1;
        #(HALF); sck = 1'b0;
      end
    end
    end_txn();
  endtask

  task automatic do_read(input logic [15:0] a, input int n, input bit rst_abort);
    logic [7:0] rx;
    logic [3:0] doe;
    doe = m_sqi ? 4'hF : 4'h2;
    begin_txn();
    xfer(8'h03, 4'h0, rx);
    xfer(a[15:8], 4'h0, rx);
    xfer(a[7:0], 4'h0, rx);
    if (m_sqi) xfer(8'h00, 4'h0, rx);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(ref_rd(a + i[15:0]));
      xfer(8'($urandom), doe, rx);
      obs_rd.push_back(rx);
    end
    if (rst_abort) begin
      #(HALF / 2);
      rst_n = 1'b0;
      #1;
      chk("rst_oe", {28'd0, sio_oe}, 32'd0);
      chk("rst_sqi", {31'd0, sqi_mode}, 32'd0);
      chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
      cs_n  = 1'b1;
      sio_i = 4'h0;
      m_sqi = 1'b0;
      m_mr  = 8'h40;
      #50;
      rst_n = 1'b1;
      #(HALF);
    end else begin
      end_txn();
    end
  endtask

  task automatic do_wrmr(input logic [7:0] v);
    logic [7:0] rx;
    begin_txn();
    xfer(8'h01, 4'h0, rx);
    xfer(v, 4'h0, rx);
    m_mr = {v[7:6], 6'b000000};
    end_txn();
  endtask

  task automatic do_rdmr(input int n);
    logic [7:0] rx;
    logic [3:0] doe;
    doe = m_sqi ? 4'hF : 4'h2;
    begin_txn();
    xfer(8'h05, 4'h0, rx);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(m_mr);
      xfer(8'($urandom), doe, rx);
      obs_rd.push_back(rx);
    end
    end_txn();
  endtask

  // Mode commands and unknown opcodes; trailing bytes must see no drive.
  task automatic do_cmd(input logic [7:0] c, input int extra);
    logic [7:0] rx;
    begin_txn();
    xfer(c, 4'h0, rx);
    if ((c == 8'h38) && !m_sqi) m_sqi = 1'b1;
    else if ((c == 8'hFF) && m_sqi) m_sqi = 1'b0;
    for (int i = 0; i < extra; i++) xfer(8'($urandom), 4'h0, rx);
    end_txn();
  endtask

  initial begin
    seed8 = 8'($urandom);
    m_sqi = 1'b0;
    m_mr  = 8'h40;
    #33;
    chk("reset_sio_o", {28'd0, sio_o}, 32'd0);
    chk("reset_oe", {28'd0, sio_oe}, 32'd0);
    chk("reset_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("reset_addr", {16'd0, mem_addr}, 32'd0);
    chk("reset_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("reset_sqi", {31'd0, sqi_mode}, 32'd0);
    rst_n = 1'b1;
    #100;

    do_wrmr(8'h40);
    do_rdmr(2);
    do_wrmr(8'hC0);
    do_rdmr(2);
    do_wrmr(8'h40);

    begin_txn();
    begin
      logic [7:0] rx;
      xfer(8'h02, 4'h0, rx); xfer(8'h12, 4'h0, rx); xfer(8'h34, 4'h0, rx);
      ref_mem[32'h1234] = 8'hAA; exp_wr.push_back({16'h1234, 8'hAA}); xfer(8'hAA, 4'h0, rx);
      ref_mem[32'h1235] = 8'h55; exp_wr.push_back({16'h1235, 8'h55}); xfer(8'h55, 4'h0, rx);
    end
    end_txn();
    do_read(16'h1234, 2, 1'b0);

    for (int k = 0; k < 4; k++) begin
      logic [15:0] a;
      a = 16'($urandom);
      do_write(a, int'($urandom_range(1, 3)), 1'b0);
      do_read(a - 16'd1, int'($urandom_range(2, 4)), 1'b0);
    end
    do_write(16'hFFFF, 2, 1'b0);
    do_read(16'hFFFE, 4, 1'b0);

    do_cmd(8'h38, 1);
    do_read(16'hFFFF, 2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      logic [15:0] a;
      a = 16'($urandom);
      do_write(a, int'($urandom_range(1, 4)), 1'b0);
      do_read(a, int'($urandom_range(1, 4)), 1'b0);
    end
    do_rdmr(2);
    do_cmd(8'h38, 2);
    do_cmd(8'h5A, 2);
    do_cmd(8'hFF, 1);
    do_read(16'h1234, 2, 1'b0);
    do_cmd(8'hFF, 2);
    do_cmd(8'h5A, 2);

    do_write(16'h4321, 1, 1'b1);
    do_read(16'h4321, 2, 1'b0);

    do_wrmr(8'h80);
    do_cmd(8'h38, 0);
    do_read(16'($urandom), 1, 1'b1);
    do_rdmr(1);
    do_read(16'h1235, 1, 1'b0);

    #500;
    chk("wr_queue_empty", exp_wr.size(), 32'd0);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
